// File: rtl/convolution_unit.sv
// convolution_unit: combinational 2-D "valid" correlation of a matrix of up
// to 5x5 unsigned 8-bit elements with a kernel of up to 3x3. The result is
// placed in slot 0 of the shared 400-bit two-matrix bus format. The result
// elements are the low 8 bits of each accumulated sum.
module convolution_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   in_m,
    input  logic [2:0]   in_n,
    input  logic [1:0]   k_m,
    input  logic [1:0]   k_n,
    input  logic [399:0] matrices_in,
    input  logic [71:0]  kernelMatrix,
    output logic [2:0]   out_m,
    output logic [2:0]   out_n,
    output logic [399:0] matrices_out,
    output logic         valid,
    output logic [9:0]   cycleCount
);

    localparam int IN_DIM  = 5;
    localparam int K_DIM   = 3;
    // Padded input grid: any (i+a, j+b) reachable by the loops stays in range.
    localparam int PAD_DIM = IN_DIM + K_DIM - 1;

    // The accumulated sum wraps to its low 8 bits; no saturation.
    function automatic logic [7:0] wrap8(input logic [19:0] sum);
        return sum[7:0];
    endfunction

    logic         legal;
    logic [2:0]   res_m;
    logic [2:0]   res_n;
    logic [7:0]   in_e [PAD_DIM][PAD_DIM];
    logic [7:0]   k_e  [K_DIM][K_DIM];
    logic [399:0] conv_bus;
    logic         legal_d;
    logic         legal_q;

    // Dimension legality, result geometry and MAC count.
    always_comb begin
        legal = (in_m >= 3'd1) && (in_m <= 3'd5) &&
                (in_n >= 3'd1) && (in_n <= 3'd5) &&
                (k_m != 2'd0) && (k_n != 2'd0) &&
                ({1'b0, k_m} <= in_m) && ({1'b0, k_n} <= in_n);
        res_m = 3'd0;
        res_n = 3'd0;
        if (legal) begin
            res_m = in_m - {1'b0, k_m} + 3'd1;
            res_n = in_n - {1'b0, k_n} + 3'd1;
        end
        out_m      = res_m;
        out_n      = res_n;
        valid      = legal;
        cycleCount = {7'd0, res_m} * {7'd0, res_n} * {8'd0, k_m} * {8'd0, k_n};
    end

    // Unpack matrix0 into a zero-padded grid, masking elements outside in_m x in_n.
    always_comb begin
        for (int r = 0; r < PAD_DIM; r++) begin
            for (int c = 0; c < PAD_DIM; c++) begin
                in_e[r][c] = 8'd0;
            end
        end
        for (int r = 0; r < IN_DIM; r++) begin
            for (int c = 0; c < IN_DIM; c++) begin
                if ((r < int'(in_m)) && (c < int'(in_n))) begin
                    in_e[r][c] = matrices_in[(r*IN_DIM + c)*8 +: 8];
                end
            end
        end
    end

    // Unpack the kernel, masking elements outside k_m x k_n.
    always_comb begin
        for (int r = 0; r < K_DIM; r++) begin
            for (int c = 0; c < K_DIM; c++) begin
                k_e[r][c] = 8'd0;
                if ((r < int'(k_m)) && (c < int'(k_n))) begin
                    k_e[r][c] = kernelMatrix[(r*K_DIM + c)*8 +: 8];
                end
            end
        end
    end

    // Multiply-accumulate every result position; unused positions stay zero.
    always_comb begin
        logic [19:0] acc;
        conv_bus = '0;
        acc      = '0;
        for (int i = 0; i < IN_DIM; i++) begin
            for (int j = 0; j < IN_DIM; j++) begin
                acc = '0;
                for (int a = 0; a < K_DIM; a++) begin
                    for (int b = 0; b < K_DIM; b++) begin
                        acc = acc + 20'(16'(in_e[i+a][j+b] * k_e[a][b]));
                    end
                end
                if (legal && (i < int'(res_m)) && (j < int'(res_n))) begin
                    conv_bus[(i*IN_DIM + j)*8 +: 8] = wrap8(acc);
                end
            end
        end
        matrices_out = conv_bus;
    end

    // Next value of the local legality observation flop.
    always_comb begin
        legal_d = legal;
    end

    // Registered legality flag for local observation; it feeds no output.
    always_ff @(posedge clk) begin
        if (reset) begin
            legal_q <= 1'b0;
        end else begin
            legal_q <= legal_d;
        end
    end

    // Bits intentionally not consumed by the datapath (slot 1 of the bus).
    logic unused_bits;
    assign unused_bits = ^{legal_q, matrices_in[399:200]};

endmodule

// File: tb/tb_convolution_unit.sv
// Self-checking bench for convolution_unit using an expected-result queue.
module tb_convolution_unit;

    logic         clk = 1'b0;
    logic         clk_en = 1'b0;
    logic         reset = 1'b0;
    logic [2:0]   in_m = '0;
    logic [2:0]   in_n = '0;
    logic [1:0]   k_m = '0;
    logic [1:0]   k_n = '0;
    logic [399:0] matrices_in = '0;
    logic [71:0]  kernelMatrix = '0;
    logic [2:0]   out_m;
    logic [2:0]   out_n;
    logic [399:0] matrices_out;
    logic         valid;
    logic [9:0]   cycleCount;

    always #5 if (clk_en) clk = ~clk;

    convolution_unit dut (
        .clk(clk), .reset(reset), .in_m(in_m), .in_n(in_n), .k_m(k_m), .k_n(k_n),
        .matrices_in(matrices_in), .kernelMatrix(kernelMatrix),
        .out_m(out_m), .out_n(out_n), .matrices_out(matrices_out),
        .valid(valid), .cycleCount(cycleCount)
    );

    typedef struct {
        string        tag;
        logic [2:0]   om;
        logic [2:0]   on;
        logic [399:0] mat;
        logic         v;
        logic [9:0]   cc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   img [5][5];
    int   ker [3][3];
    int   cur_im, cur_in, cur_km, cur_kn;

    task automatic check(input string tag, input logic [399:0] obs, input logic [399:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model from the unpacked stimulus arrays.
    task automatic push_expected(input string tag);
        exp_t e;
        bit   lg;
        int   s;
        lg = (cur_im >= 1) && (cur_im <= 5) && (cur_in >= 1) && (cur_in <= 5) &&
             (cur_km >= 1) && (cur_kn >= 1) && (cur_km <= cur_im) && (cur_kn <= cur_in);
        e.tag = tag;
        e.mat = '0;
        e.v   = lg;
        e.om  = lg ? 3'(cur_im - cur_km + 1) : 3'd0;
        e.on  = lg ? 3'(cur_in - cur_kn + 1) : 3'd0;
        e.cc  = lg ? 10'((cur_im - cur_km + 1) * (cur_in - cur_kn + 1) * cur_km * cur_kn) : 10'd0;
        if (lg) begin
            for (int i = 0; i <= cur_im - cur_km; i++) begin
                for (int j = 0; j <= cur_in - cur_kn; j++) begin
                    s = 0;
                    for (int a = 0; a < cur_km; a++)
                        for (int b = 0; b < cur_kn; b++)
                            s += img[i+a][j+b] * ker[a][b];
                    e.mat[(i*5+j)*8 +: 8] = 8'(s % 256);
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 400'd1, 400'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_valid"}, 400'(valid), 400'(e.v));
        check({e.tag, "_out_m"}, 400'(out_m), 400'(e.om));
        check({e.tag, "_out_n"}, 400'(out_n), 400'(e.on));
        check({e.tag, "_cc"}, 400'(cycleCount), 400'(e.cc));
        check({e.tag, "_mat"}, matrices_out, e.mat);
        check({e.tag, "_hi0"}, 400'(matrices_out[399:200]), 400'd0);
    endtask

    // Pack arrays onto the buses; garbage fills unused slots and the upper half.
    task automatic drive(input int im, input int in_, input int km, input int kn, input bit garbage);
        logic [399:0] mi;
        logic [71:0]  kv;
        cur_im = im; cur_in = in_; cur_km = km; cur_kn = kn;
        mi = '0;
        kv = '0;
        for (int p = 0; p < 50; p++) mi[p*8 +: 8] = garbage ? 8'($urandom_range(0, 255)) : 8'd0;
        for (int p = 0; p < 9; p++)  kv[p*8 +: 8] = garbage ? 8'($urandom_range(0, 255)) : 8'd0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (r < im && c < in_) mi[(r*5+c)*8 +: 8] = 8'(img[r][c]);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (r < km && c < kn) kv[(r*3+c)*8 +: 8] = 8'(ker[r][c]);
        in_m = 3'(im); in_n = 3'(in_); k_m = 2'(km); k_n = 2'(kn);
        matrices_in = mi;
        kernelMatrix = kv;
    endtask

    task automatic apply(input string tag, input int im, input int in_, input int km,
                         input int kn, input bit garbage);
        drive(im, in_, km, kn, garbage);
        push_expected(tag);
        #1;
        drain();
    endtask

    task automatic load_case1();
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = r*4 + c + 1;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) ker[r][c] = 1;
    endtask

    logic [399:0] c1_ref;

    initial begin
        // Hand-computed result of case 1.
        c1_ref = '0;
        c1_ref[0*8 +: 8]  = 8'd14; c1_ref[1*8 +: 8]  = 8'd18; c1_ref[2*8 +: 8]  = 8'd22;
        c1_ref[5*8 +: 8]  = 8'd30; c1_ref[6*8 +: 8]  = 8'd34; c1_ref[7*8 +: 8]  = 8'd38;
        c1_ref[10*8 +: 8] = 8'd46; c1_ref[11*8 +: 8] = 8'd50; c1_ref[12*8 +: 8] = 8'd54;

        // Case 1, no clock running.
        load_case1();
        apply("c1", 4, 4, 2, 2, 1'b0);
        check("c1_const_mat", matrices_out, c1_ref);
        check("c1_const_cc", 400'(cycleCount), 400'd36);

        // Case 2: saturating-free wrap 1800 mod 256 = 8.
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = 200;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) ker[r][c] = 1;
        apply("c2", 5, 5, 3, 3, 1'b0);
        check("c2_const_e00", 400'(matrices_out[7:0]), 400'd8);
        check("c2_const_e22", 400'(matrices_out[12*8 +: 8]), 400'd8);
        check("c2_const_cc", 400'(cycleCount), 400'd81);

        // Case 3: kernel equals input size, identity diagonal.
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) begin
            img[r][c] = r*3 + c + 1;
            ker[r][c] = (r == c) ? 1 : 0;
        end
        apply("c3", 3, 3, 3, 3, 1'b0);
        check("c3_const_e00", 400'(matrices_out[7:0]), 400'd15);
        check("c3_const_cc", 400'(cycleCount), 400'd9);

        // Case 4: illegal dimensions.
        apply("c4_kbig", 2, 2, 3, 1, 1'b1);
        apply("c4_m0", 0, 3, 1, 1, 1'b1);
        apply("c4_n6", 3, 6, 1, 1, 1'b1);
        apply("c4_k0", 3, 3, 0, 2, 1'b1);

        // 1x1 kernel scales input modulo 256.
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = 50 + r*20 + c*7;
        ker[0][0] = 7;
        apply("k1x1", 5, 5, 1, 1, 1'b1);
        check("k1x1_const_e44", 400'(matrices_out[24*8 +: 8]), 400'(((50 + 80 + 28) * 7) % 256));

        // Case 5: garbage outside the used region.
        load_case1();
        apply("c5", 4, 4, 2, 2, 1'b1);
        check("c5_const_mat", matrices_out, c1_ref);

        // Random dimensions and data, legal and illegal.
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = $urandom_range(0, 255);
            for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) ker[r][c] = $urandom_range(0, 255);
            apply("rnd", $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end

        // Case 6: clock and reset activity must not disturb outputs.
        load_case1();
        drive(4, 4, 2, 2, 1'b0);
        clk_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push_expected("c6");
            reset = (k % 3 == 1);
            @(posedge clk);
            #1;
            drain();
            check("c6_const_mat", matrices_out, c1_ref);
        end
        reset = 1'b0;
        clk_en = 1'b0;

        if (sb.size() != 0) check("sb_leftover", 400'(sb.size()), 400'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
